// File: rtl/mmio_uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mmio_uart_pkg
// Brief    : Shared constants and types for the memory-mapped UART transmitter.
//            Register word indices, STATUS bit positions, shifter state enum.
//            Optional macro: MMIO_UART_PARITY_EN (adds the even-parity state).
// Revision : 1.0 - initial release
// ============================================================================
package mmio_uart_pkg;

    // Register word index, taken from addr[3:2]
    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_DIV    = 2'd2;
    localparam logic [1:0] REG_RSVD   = 2'd3;

    // STATUS bit positions
    localparam int ST_FULL    = 0;
    localparam int ST_EMPTY   = 1;
    localparam int ST_BUSY    = 2;
    localparam int ST_OVF     = 3;
    localparam int ST_CNT_LSB = 4;

    // Serial shifter states
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef MMIO_UART_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4
    } tx_state_t;

    // Even parity: the parity bit makes the total count of ones even
    function automatic logic even_parity(input logic [7:0] b);
        return ^b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_shifter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_shifter
// Brief    : Serialises one byte per valid/ready handshake into a UART frame
//            (start, 8 data LSB first, [even parity], stop). The divisor is
//            latched when a frame is accepted, so later changes only affect
//            later frames. Optional macro: MMIO_UART_PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_shifter
    import mmio_uart_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_valid,
    input  logic [7:0]  i_data,
    input  logic [15:0] i_div,
    output logic        o_ready,
    output logic        o_tx,
    output logic        o_busy
);

    tx_state_t   r_state;
    logic [15:0] r_div;
    logic [15:0] r_cnt;
    logic [7:0]  r_shreg;
    logic [2:0]  r_bit;
`ifdef MMIO_UART_PARITY_EN
    logic        r_par;
`endif

    // A zero divisor behaves like one clock per bit
    logic [15:0] w_div_eff;
    logic        w_bit_end;
    assign w_div_eff = (i_div == 16'd0) ? 16'd1 : i_div;
    assign w_bit_end = (r_cnt == 16'd0);

    // A new byte may be taken when idle or on the last cycle of the stop bit
    assign o_ready = (r_state == S_IDLE) || ((r_state == S_STOP) && w_bit_end);
    assign o_busy  = (r_state != S_IDLE);

    // Frame sequencer: each bit is held for r_div cycles via r_cnt countdown
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
            o_tx    <= 1'b1;
            r_div   <= 16'd1;
            r_cnt   <= 16'd0;
            r_shreg <= 8'd0;
            r_bit   <= 3'd0;
`ifdef MMIO_UART_PARITY_EN
            r_par   <= 1'b0;
`endif
        end else begin
            if (!w_bit_end) begin
                r_cnt <= r_cnt - 16'd1;
            end
            case (r_state)
                S_IDLE: begin
                    if (i_valid) begin
                        r_state <= S_START;
                        o_tx    <= 1'b0;
                        r_shreg <= i_data;
                        r_div   <= w_div_eff;
                        r_cnt   <= w_div_eff - 16'd1;
`ifdef MMIO_UART_PARITY_EN
                        r_par   <= even_parity(i_data);
`endif
                    end
                end
                S_START: begin
                    if (w_bit_end) begin
                        r_state <= S_DATA;
                        o_tx    <= r_shreg[0];
                        r_shreg <= {1'b0, r_shreg[7:1]};
                        r_bit   <= 3'd0;
                        r_cnt   <= r_div - 16'd1;
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        r_cnt <= r_div - 16'd1;
                        if (r_bit == 3'd7) begin
`ifdef MMIO_UART_PARITY_EN
                            r_state <= S_PARITY;
                            o_tx    <= r_par;
`else
                            r_state <= S_STOP;
                            o_tx    <= 1'b1;
`endif
                        end else begin
                            o_tx    <= r_shreg[0];
                            r_shreg <= {1'b0, r_shreg[7:1]};
                            r_bit   <= r_bit + 3'd1;
                        end
                    end
                end
`ifdef MMIO_UART_PARITY_EN
                S_PARITY: begin
                    if (w_bit_end) begin
                        r_state <= S_STOP;
                        o_tx    <= 1'b1;
                        r_cnt   <= r_div - 16'd1;
                    end
                end
`endif
                S_STOP: begin
                    if (w_bit_end) begin
                        if (i_valid) begin
                            // Back-to-back: straight into the next start bit
                            r_state <= S_START;
                            o_tx    <= 1'b0;
                            r_shreg <= i_data;
                            r_div   <= w_div_eff;
                            r_cnt   <= w_div_eff - 16'd1;
`ifdef MMIO_UART_PARITY_EN
                            r_par   <= even_parity(i_data);
`endif
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    o_tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/mmio_uart.sv
`default_nettype none
// ============================================================================
// Module   : mmio_uart
// Brief    : Memory-mapped UART transmitter on the core's data port. Register
//            decode, TX FIFO and overflow tracking live here; framing is done
//            by uart_tx_shifter. Optional macro: MMIO_UART_PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mmio_uart
    import mmio_uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'hFFFF_0000,
    parameter int          DEPTH     = 4,
    parameter logic [15:0] DIV_RESET = 16'd868
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:2] addr,
    input  logic [31:0] din,
    input  logic        en,
    input  logic        we,
    output logic [31:0] dout,
    output logic        hit,
    output logic        tx
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;
    localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(DEPTH);

    logic [7:0]         r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wptr;
    logic [c_ptr_w-1:0] r_rptr;
    logic [c_cnt_w-1:0] r_count;
    logic               r_ovf;
    logic [15:0]        r_div;

    logic        w_sel;
    logic [1:0]  w_idx;
    logic        w_full;
    logic        w_empty;
    logic        w_busy;
    logic        w_ready;
    logic        w_pop;
    logic        w_push_req;
    logic        w_push;
    logic        w_ovf_evt;
    logic        w_ovf_clr;
    logic [31:0] w_status;
    logic        w_unused_din;

    assign w_sel      = en && (addr[31:4] == BASE_ADDR[31:4]);
    assign w_idx      = addr[3:2];
    assign w_full     = (r_count == c_depth);
    assign w_empty    = (r_count == '0);
    assign w_pop      = !w_empty && w_ready;
    assign w_push_req = w_sel && we && (w_idx == REG_DATA);
    // A pop on the same edge frees the slot, so a full FIFO still accepts
    assign w_push     = w_push_req && (!w_full || w_pop);
    assign w_ovf_evt  = w_push_req && w_full && !w_pop;
    assign w_ovf_clr  = w_sel && we && (w_idx == REG_STATUS) && din[ST_OVF];
    assign w_unused_din = &{1'b0, din[31:16]};

    // STATUS word assembly
    always_comb begin
        w_status                    = 32'd0;
        w_status[ST_FULL]           = w_full;
        w_status[ST_EMPTY]          = w_empty;
        w_status[ST_BUSY]           = w_busy;
        w_status[ST_OVF]            = r_ovf;
        w_status[ST_CNT_LSB +: 4]   = 4'(r_count);
    end

    // FIFO storage; contents need no reset since count gates every read
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= din[7:0];
        end
    end

    // Pointers, count, overflow, divisor and registered read port
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_div   <= DIV_RESET;
            dout    <= 32'd0;
            hit     <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase

            // A fresh overflow on the same edge outranks the W1C clear
            if (w_ovf_evt) begin
                r_ovf <= 1'b1;
            end else if (w_ovf_clr) begin
                r_ovf <= 1'b0;
            end

            if (w_sel && we && (w_idx == REG_DIV)) begin
                r_div <= din[15:0];
            end

            hit  <= w_sel && !we;
            dout <= 32'd0;
            if (w_sel && !we) begin
                case (w_idx)
                    REG_DATA:   dout <= 32'd0;
                    REG_STATUS: dout <= w_status;
                    REG_DIV:    dout <= {16'd0, r_div};
                    REG_RSVD:   dout <= 32'd0;
                    default:    dout <= 32'd0;
                endcase
            end
        end
    end

    uart_tx_shifter u_shifter (
        .clk     (clk),
        .rst     (rst),
        .i_valid (!w_empty),
        .i_data  (r_mem[r_rptr]),
        .i_div   (r_div),
        .o_ready (w_ready),
        .o_tx    (tx),
        .o_busy  (w_busy)
    );

endmodule
`default_nettype wire

// File: doc/mmio_uart.md
# mmio_uart

Memory-mapped serial transmitter that responds to the CPU data-memory port (the same word-addressed `addr/din/dout/en/we` protocol the core drives toward `memory`). Stores software writes in a small TX FIFO and shifts them out as 8N1 UART frames on a single output pin. Sits beside `memory` on the data port; the top level muxes `dout` using `hit`.

## Interface
- `BASE_ADDR`, 32'hFFFF_0000: 16-byte window; decode on `addr[31:4] == BASE_ADDR[31:4]`.
- `DEPTH`, 4: TX FIFO entries; power of two, 2..8.
- `DIV_RESET`, 16'd868: reset value of the divisor register (clocks per bit).
- `clk`  in  1  sole clock.
- `rst`  in  1  synchronous, active-low reset.
- `addr`  in  [31:2]  word address from the core.
- `din`  in  32  write data.
- `en`  in  1  access strobe.
- `we`  in  1  write when `en` is high; read otherwise.
- `dout`  out  32  registered read data.
- `hit`  out  1  registered; high the cycle `dout` carries this block's data.
- `tx`  out  1  serial line, idle high.

## Operation
- Register map, word index `addr[3:2]`: 0 DATA (W: push `din[7:0]`; R: 0), 1 STATUS (R; W1C on bit 3), 2 DIV (R/W, `[15:0]`, upper bits read 0), 3 reserved (R: 0, writes ignored).
- STATUS: [0] full, [1] empty, [2] busy (shifter mid-frame), [3] overflow (sticky), [7:4] FIFO count; other bits 0.
- Selected access = `en && addr in window`; unselected accesses have no effect and produce `hit`=0.
- DATA write while full: byte dropped, overflow set. Write to STATUS with `din[3]`=1 clears overflow; same-cycle overflow event wins (stays set).
- Shifter states IDLE -> START -> DATA(8 bits, LSB first) -> [PARITY] -> STOP -> IDLE. Each bit lasts `max(DIV,1)` cycles; DIV sampled into the shifter on leaving IDLE, so DIV writes mid-frame affect only later frames.
- IDLE with FIFO non-empty: pop head and enter START on the same edge. Back-to-back frames: STOP -> START directly if FIFO non-empty, no idle bit.
- Simultaneous push and pop: both occur, count unchanged; push into full FIFO while a pop occurs that edge is accepted (not an overflow).
- Pointers wrap modulo DEPTH; count is `$clog2(DEPTH)+1` bits.

## Timing
- Reset values: `dout`=0, `hit`=0, `tx`=1, FIFO empty, overflow=0, DIV=`DIV_RESET`, shifter IDLE. Reset mid-frame aborts the frame; `tx` is 1 the cycle after the reset edge.
- Read latency 1: selected read at edge N -> `dout`/`hit` valid after edge N, held until the next edge. Writes take effect at the sampling edge; a read of STATUS one cycle after a DATA write reflects the push.
- Frame on `tx` starts the cycle after the pop edge, i.e. earliest 2 cycles after the DATA write edge if idle.
- Frame length: 10 bits x DIV cycles (11 with parity).

## Configuration
- `MMIO_UART_PARITY_EN` defined: an even-parity bit is inserted between bit 7 and STOP; STATUS unchanged. Undefined: plain 8N1, PARITY state absent.

## Structure
- Package `mmio_uart_pkg`: register index constants (`REG_DATA`, `REG_STATUS`, `REG_DIV`), STATUS bit positions, shifter state enum.
- One sub-module `uart_tx_shifter`: takes byte + divisor with valid/ready handshake, drives `tx` and `busy`. FIFO and register decode live in `mmio_uart`.

## Test plan
- Reset with `rst`=0, then read STATUS -> `dout`=32'h0000_0002 (empty), `tx`=1, DIV reads 868.
- DIV=4, write DATA 8'h55 -> `tx` = 0,1,0,1,0,1,0,1,0,1 each for 4 cycles (40 cycles), then idle high; busy deasserts after STOP.
- DIV=2, write 6 bytes back-to-back with DEPTH=4 -> first accepted bytes plus one freed slot hold; STATUS shows overflow=1, count correct; W1C write of 8 clears bit 3.
- Push and pop on the same edge with FIFO full -> no overflow, count stays 4.
- Write DIV=8 mid-frame at DIV=4 -> current frame keeps 4-cycle bits, next frame uses 8.
- Assert `rst`=0 during DATA bit 3 -> `tx`=1 next cycle, FIFO empty, no residual frame; access outside window (addr word 0x0000_0100) -> `hit`=0, no state change.
